// File: rtl/tps_pkg.sv
// rtl/tps_pkg.sv - shared defaults for the tick PWM shaper
// Holds default width, reset shadow values and the synchroniser depth floor.
package tps_pkg;

    localparam int TPS_W               = 8;
    localparam int TPS_PERIOD_RST      = 10;
    localparam int TPS_DUTY_RST        = 5;
    localparam int TPS_SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/tick_pwm_shaper_sync_edge.sv
// rtl/tick_pwm_shaper_sync_edge.sv - synchroniser and rising-edge pulse (module tps_sync_edge)
// Ports: clk, rst (async active-low), async_in (unsynchronised level),
//        pulse (registered one-cycle pulse per accepted rising edge).
// Build option TPS_GLITCH_FILTER_EN: the synchronised level must be high on
// two consecutive clocks after a low before a pulse is issued.
module tps_sync_edge
    import tps_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    // Depth is clamped so a misconfigured instance still gets a real synchroniser.
    localparam int NS = (SYNC_STAGES < TPS_SYNC_STAGES_MIN) ? TPS_SYNC_STAGES_MIN : SYNC_STAGES;

    logic [NS-1:0] sync_q;
    logic          lvl;
    logic          prev_q;

    assign lvl = sync_q[NS-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NS-2:0], async_in};
        end
    end

`ifdef TPS_GLITCH_FILTER_EN
    logic filt_q;

    // lvl is the newest sample, filt_q the one before, prev_q the one before that:
    // accept only the pattern 0,1,1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            filt_q <= lvl;
            prev_q <= filt_q;
            pulse  <= lvl & filt_q & ~prev_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            prev_q <= lvl;
            pulse  <= lvl & ~prev_q;
        end
    end
`endif

endmodule

// File: rtl/tick_pwm_shaper.sv
// rtl/tick_pwm_shaper.sv - tick counter with shadowed period/duty PWM and square wave
// Ports: clk, rst (async active-low), en (count enable), tc_in (async terminal
//        count), period/duty/load (shadow update request), tick (accepted edge),
//        cnt (tick index), cyc_done (wrap strobe), pwm_out, sq_out.
// Build option TPS_GLITCH_FILTER_EN is handled inside tps_sync_edge.
module tick_pwm_shaper
    import tps_pkg::*;
#(
    parameter int W           = TPS_W,
    parameter int SYNC_STAGES = TPS_SYNC_STAGES_MIN,
    parameter int PERIOD_RST  = TPS_PERIOD_RST,
    parameter int DUTY_RST    = TPS_DUTY_RST
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         tc_in,
    input  logic [W-1:0] period,
    input  logic [W-1:0] duty,
    input  logic         load,
    output logic         tick,
    output logic [W-1:0] cnt,
    output logic         cyc_done,
    output logic         pwm_out,
    output logic         sq_out
);

    logic [W-1:0] per_sh, duty_sh;
    logic         pending;

    logic [W-1:0] eff_per;
    logic         wrap;
    logic [W-1:0] cnt_nxt, per_nxt, duty_nxt;
    logic         pend_nxt;

    tps_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (tc_in),
        .pulse    (tick)
    );

    always_comb begin
        eff_per  = (per_sh == '0) ? W'(1) : per_sh;
        wrap     = tick & en & (cnt == eff_per - W'(1));
        cnt_nxt  = cnt;
        per_nxt  = per_sh;
        duty_nxt = duty_sh;
        pend_nxt = pending | load;
        if (!en) begin
            // Idle: nothing is mid-period, so a load can take effect at once.
            if (load) begin
                cnt_nxt  = '0;
                per_nxt  = period;
                duty_nxt = duty;
                pend_nxt = 1'b0;
            end
        end else if (wrap) begin
            cnt_nxt = '0;
            if (pending || load) begin
                per_nxt  = period;
                duty_nxt = duty;
                pend_nxt = 1'b0;
            end
        end else if (tick) begin
            cnt_nxt = cnt + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            per_sh   <= W'(PERIOD_RST);
            duty_sh  <= W'(DUTY_RST);
            pending  <= 1'b0;
            cyc_done <= 1'b0;
            pwm_out  <= 1'b0;
            sq_out   <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            per_sh   <= per_nxt;
            duty_sh  <= duty_nxt;
            pending  <= pend_nxt;
            cyc_done <= wrap;
            // Compare against the values being registered so pwm_out lines up with cnt.
            pwm_out  <= (cnt_nxt < duty_nxt);
            if (wrap) begin
                sq_out <= ~sq_out;
            end
        end
    end

endmodule

// File: tb/tb_tick_pwm_shaper.sv
// tb/tb_tick_pwm_shaper.sv - self-checking bench for tick_pwm_shaper
module tb_tick_pwm_shaper;

`ifdef TPS_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst, en, tc_in, load;
    logic [7:0] period, duty;
    logic       tick, cyc_done, pwm_out, sq_out;
    logic [7:0] cnt;

    tick_pwm_shaper dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .tc_in    (tc_in),
        .period   (period),
        .duty     (duty),
        .load     (load),
        .tick     (tick),
        .cnt      (cnt),
        .cyc_done (cyc_done),
        .pwm_out  (pwm_out),
        .sq_out   (sq_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         exp_edge;
        logic [7:0] cnt;
        logic       cyc;
        logic       pwm;
        logic       sq;
    } item_t;

    typedef struct {
        bit         do_load;
        logic [7:0] period;
        logic [7:0] duty;
        int         npulses;
        int         exp_wraps;
        int         exp_pwm_hi;
        logic [7:0] exp_cnt;
    } row_t;

    item_t q[$];
    item_t cur;
    bit    chk_pending = 0;
    int    ecount = 0;
    int    n_cmp = 0, n_bad = 0;
    int    n_cyc_seen = 0, n_pwm_hi = 0;

    // Reference state of the shaper, advanced when a tc_in edge is driven.
    logic [7:0] m_cnt, m_per, m_duty;
    logic       m_sq, m_pend;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_per = 10; m_duty = 5; m_sq = 0; m_pend = 0;
    endtask

    task automatic push_tick(input bit ld);
        item_t      it;
        logic [7:0] eff;
        bit         wrap;
        wrap = 0;
        if (en) begin
            eff  = (m_per == 0) ? 8'd1 : m_per;
            wrap = (m_cnt == eff - 8'd1);
            if (wrap) begin
                m_cnt = 0;
                m_sq  = ~m_sq;
                if (m_pend || ld) begin
                    m_per = period; m_duty = duty; m_pend = 0;
                end
            end else begin
                m_cnt = m_cnt + 8'd1;
                if (ld) m_pend = 1;
            end
        end
        it.exp_edge = ecount + LAT;
        it.cnt = m_cnt;
        it.cyc = wrap;
        it.pwm = (m_cnt < m_duty);
        it.sq  = m_sq;
        q.push_back(it);
    endtask

    // One tc_in pulse; when ld is set, load is raised in the cycle the tick is high.
    task automatic pulse(input int hi, input bit ld);
        @(negedge clk);
        push_tick(ld);
        tc_in = 1;
        for (int k = 1; k <= hi + 6; k++) begin
            @(negedge clk);
            if (k == hi) tc_in = 0;
            if (ld && k == LAT) load = 1;
            if (k == LAT + 1) load = 0;
        end
    endtask

    task automatic idle_load(input logic [7:0] p, input logic [7:0] d);
        @(negedge clk);
        en = 0; period = p; duty = d; load = 1;
        @(negedge clk);
        load = 0;
        m_cnt = 0; m_per = p; m_duty = d; m_pend = 0;
        chk("idle_load_cnt", cnt, 0);
        chk("idle_load_pwm", pwm_out, (8'd0 < d));
        en = 1;
    endtask

    always @(posedge clk) ecount++;

    always @(negedge clk) begin
        if (!rst) begin
            chk_pending = 0;
        end else begin
            if (cyc_done) n_cyc_seen++;
            if (chk_pending) begin
                chk("cnt", cnt, cur.cnt);
                chk("cyc_done", cyc_done, cur.cyc);
                chk("pwm_out", pwm_out, cur.pwm);
                chk("sq_out", sq_out, cur.sq);
                if (pwm_out) n_pwm_hi++;
                chk_pending = 0;
            end else begin
                chk("cyc_done_idle", cyc_done, 0);
            end
            if (tick) begin
                if (q.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("tick_latency_edge", ecount, cur.exp_edge);
                    chk_pending = 1;
                end
            end
        end
    end

    row_t rows[6];

    initial begin
        rows[0] = '{0, 8'd10,  8'd5,   25, 2, 14, 8'd5};
        rows[1] = '{1, 8'd6,   8'd0,    7, 1,  0, 8'd1};
        rows[2] = '{1, 8'd6,   8'd7,    7, 1,  7, 8'd1};
        rows[3] = '{1, 8'd0,   8'd0,    3, 3,  0, 8'd0};
        rows[4] = '{1, 8'd0,   8'd1,    3, 3,  3, 8'd0};
        rows[5] = '{1, 8'd255, 8'd128,  5, 0,  5, 8'd5};

        rst = 0; en = 1; tc_in = 0; load = 0; period = 10; duty = 5;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_cyc", cyc_done, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_sq", sq_out, 0);
        rst = 1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            if (rows[r].do_load) idle_load(rows[r].period, rows[r].duty);
            n_cyc_seen = 0;
            n_pwm_hi = 0;
            for (int i = 0; i < rows[r].npulses; i++) pulse(3, 0);
            repeat (2) @(negedge clk);
            chk($sformatf("row%0d_wraps", r), n_cyc_seen, rows[r].exp_wraps);
            chk($sformatf("row%0d_pwm_hi", r), n_pwm_hi, rows[r].exp_pwm_hi);
            chk($sformatf("row%0d_cnt", r), cnt, rows[r].exp_cnt);
        end

        // Mid-cycle load at cnt=6: old 10/5 runs to the wrap, then 4/1.
        idle_load(8'd10, 8'd5);
        for (int i = 0; i < 6; i++) pulse(3, 0);
        chk("mid_load_cnt6", cnt, 6);
        @(negedge clk);
        period = 4; duty = 1; load = 1;
        @(negedge clk);
        load = 0;
        m_pend = 1;
        for (int i = 0; i < 8; i++) pulse(3, 0);

        // Load coincident with the wrap tick takes effect at that wrap.
        for (int i = 0; i < 3; i++) pulse(3, 0);
        period = 6; duty = 2;
        pulse(3, 1);
        for (int i = 0; i < 6; i++) pulse(3, 0);

        // Repeated loads: the values present at the wrap win.
        @(negedge clk);
        period = 5; duty = 1; load = 1;
        @(negedge clk);
        period = 3; duty = 3;
        @(negedge clk);
        load = 0;
        m_pend = 1;
        for (int i = 0; i < 9; i++) pulse(3, 0);

        // en low across a tc_in rise, then raised while tc_in still high.
        @(negedge clk);
        en = 0;
        pulse(3, 0);
        @(negedge clk);
        en = 0;
        push_tick(0);
        tc_in = 1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == LAT + 3) en = 1;
        end
        chk("en_hold_cnt", cnt, m_cnt);
        tc_in = 0;
        repeat (4) @(negedge clk);

        idle_load(8'd7, 8'd3);
        for (int i = 0; i < 8; i++) pulse(3, 0);

        // Asynchronous reset at cnt=7 with a load pending.
        idle_load(8'd10, 8'd5);
        for (int i = 0; i < 7; i++) pulse(3, 0);
        chk("pre_rst_cnt", cnt, 7);
        @(negedge clk);
        period = 4; duty = 1; load = 1;
        @(negedge clk);
        load = 0;
        #2 rst = 0;
        #1;
        chk("arst_tick", tick, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_cyc", cyc_done, 0);
        chk("arst_pwm", pwm_out, 0);
        chk("arst_sq", sq_out, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 11; i++) pulse(3, 0);

`ifdef TPS_GLITCH_FILTER_EN
        @(negedge clk);
        tc_in = 1;
        @(negedge clk);
        tc_in = 0;
        repeat (8) @(negedge clk);
        pulse(3, 0);
`endif

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
